gate_selftest_seq: RTL

- Self-test sequencer for the 4-in/2-out gate unit:
  - out[0] = in[0] AND in[1].
  - out[1] = in[2] OR in[3].
- On start, steps all 16 input vectors into the unit, waits a programmable settle time, and checks the unit's outputs against an internally computed expected value.
- Reports pass/fail, a mismatch count and the first failing vector.
- Sits beside the gate unit; drives its input bus and observes its output bus.

---
 rtl/gate_selftest_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/gate_selftest_seq.sv
// Self-test sequencer for the 4-in/2-out gate unit.
// Walks all 16 input vectors into the unit, waits a programmable settle time,
// and compares the unit's outputs against out[0]=in0&in1, out[1]=in2|in3.
// Reports pass/fail, a saturating mismatch count and the first failing vector.
module gate_selftest_seq #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned ERR_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       dut_in,
    input  logic [1:0]       dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       first_err_vec,
    output logic             first_err_valid
);

    localparam int unsigned VEC_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OUT_W = 2;

    localparam logic [VEC_W-1:0] VEC_LAST  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
    // A zero settle time skips WAIT entirely.
    localparam bit               HAS_WAIT  = (SETTLE_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [VEC_W-1:0] vec;
    logic [VEC_W-1:0] vec_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] settle_cnt_nxt;

    logic [VEC_W-1:0] dut_in_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             pass_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;
    logic [VEC_W-1:0] first_err_vec_nxt;
    logic             first_err_valid_nxt;

    logic [OUT_W-1:0] exp_c;
    logic             mismatch_c;
    logic [ERR_W-1:0] err_inc_c;

    // Golden gate response for the vector currently under test.
    always_comb begin
        exp_c      = {vec[2] | vec[3], vec[0] & vec[1]};
        mismatch_c = (dut_out != exp_c);
        err_inc_c  = (err_cnt == ERR_MAX) ? err_cnt : (err_cnt + ERR_W'(1));
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            vec             <= '0;
            settle_cnt      <= '0;
            dut_in          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            state           <= state_nxt;
            vec             <= vec_nxt;
            settle_cnt      <= settle_cnt_nxt;
            dut_in          <= dut_in_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            pass            <= pass_nxt;
            err_cnt         <= err_cnt_nxt;
            first_err_vec   <= first_err_vec_nxt;
            first_err_valid <= first_err_valid_nxt;
        end
    end

    // Next-state and next-output logic; results hold unless a state updates them.
    always_comb begin
        state_nxt           = state;
        vec_nxt             = vec;
        settle_cnt_nxt      = settle_cnt;
        dut_in_nxt          = dut_in;
        busy_nxt            = busy;
        done_nxt            = 1'b0;
        pass_nxt            = pass;
        err_cnt_nxt         = err_cnt;
        first_err_vec_nxt   = first_err_vec;
        first_err_valid_nxt = first_err_valid;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt           = S_DRIVE;
                    vec_nxt             = '0;
                    dut_in_nxt          = '0;
                    busy_nxt            = 1'b1;
                    pass_nxt            = 1'b0;
                    err_cnt_nxt         = '0;
                    first_err_vec_nxt   = '0;
                    first_err_valid_nxt = 1'b0;
                end
            end

            S_DRIVE: begin
                settle_cnt_nxt = SETTLE_LD;
                state_nxt      = HAS_WAIT ? S_WAIT : S_CHECK;
            end

            S_WAIT: begin
                settle_cnt_nxt = settle_cnt - CNT_W'(1);
                if (settle_cnt <= CNT_W'(1)) begin
                    state_nxt = S_CHECK;
                end
            end

            S_CHECK: begin
                if (mismatch_c) begin
                    err_cnt_nxt = err_inc_c;
                    if (!first_err_valid) begin
                        first_err_vec_nxt   = vec;
                        first_err_valid_nxt = 1'b1;
                    end
                end
                if (vec == VEC_LAST) begin
                    // pass is settled on entry so it is valid alongside done.
                    state_nxt = S_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = mismatch_c ? 1'b0 : (err_cnt == '0);
                end else begin
                    state_nxt  = S_DRIVE;
                    vec_nxt    = vec + VEC_W'(1);
                    dut_in_nxt = vec + VEC_W'(1);
                end
            end

            S_DONE: begin
                state_nxt  = S_IDLE;
                dut_in_nxt = '0;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
